// File: rtl/logic_4b_arbiter_pkg.sv
// Shared opcode and FSM state definitions for the 4-bit logic arbiter and its
// bitwise unit.
package logic_4b_arbiter_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/logic_4b_unit.sv
// Combinational 4-bit bitwise logic unit shared by all requesters.
// The y operand is ignored for NOT x and PASS x.
module logic_4b_unit
  import logic_4b_arbiter_pkg::*;
(
  input  logic [2:0] op_i,
  input  logic [3:0] x_i,
  input  logic [3:0] y_i,
  output logic [3:0] o_o
);

  always_comb begin
    o_o = x_i;
    case (op_i)
      OP_AND:  o_o = x_i & y_i;
      OP_OR:   o_o = x_i | y_i;
      OP_NAND: o_o = ~(x_i & y_i);
      OP_NOR:  o_o = ~(x_i | y_i);
      OP_XOR:  o_o = x_i ^ y_i;
      OP_XNOR: o_o = ~(x_i ^ y_i);
      OP_NOT:  o_o = ~x_i;
      OP_PASS: o_o = x_i;
      default: o_o = x_i;
    endcase
  end

endmodule

// File: rtl/logic_4b_arbiter.sv
// Round-robin arbiter that shares one 4-bit logic unit between NUM_REQ
// requesters; one transaction at a time through IDLE -> EXEC -> RESP.
module logic_4b_arbiter
  import logic_4b_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [3*NUM_REQ-1:0] req_op,
  input  logic [4*NUM_REQ-1:0] req_x,
  input  logic [4*NUM_REQ-1:0] req_y,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [3:0]           rsp_data,
  output logic                 busy
);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_q;
  logic [ID_W-1:0]   id_q;
  logic [2:0]        op_q;
  logic [3:0]        x_q, y_q;
  logic [3:0]        rsp_data_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [ID_W-1:0]   win_id;
  logic              win_found;
  logic              accept;
  logic [3:0]        unit_o;

  // Priority search starts just after the last served requester and wraps.
  always_comb begin
    win_found = 1'b0;
    win_id    = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && req_valid[(int'(last_q) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win_id    = ID_W'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

  assign accept = (state_q == S_IDLE) && win_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (win_found) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_id] = 1'b1;
    busy      = (state_q != S_IDLE);
    rsp_valid = (state_q == S_RESP);
  end

  // Operand latches carry no reset; they are only read after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      id_q <= win_id;
      op_q <= req_op[3*win_id +: 3];
      x_q  <= req_x[4*win_id +: 4];
      y_q  <= req_y[4*win_id +: 4];
    end
  end

  logic_4b_unit u_unit (
    .op_i (op_q),
    .x_i  (x_q),
    .y_i  (y_q),
    .o_o  (unit_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q <= 4'b0000;
      rsp_id_q   <= '0;
      last_q     <= ID_W'(NUM_REQ - 1);
    end else begin
      if (state_q == S_EXEC) begin
        rsp_data_q <= unit_o;
        rsp_id_q   <= id_q;
      end
      if (state_q == S_RESP && rsp_ready) last_q <= rsp_id_q;
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_id   = rsp_id_q;

endmodule

// File: tb/tb_logic_4b_arbiter.sv
// Directed bench for logic_4b_arbiter: vector table for single transactions,
// plus hand-written rotation, backpressure, priority and reset sequences.
module tb_logic_4b_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [3*NUM_REQ-1:0] req_op;
  logic [4*NUM_REQ-1:0] req_x;
  logic [4*NUM_REQ-1:0] req_y;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [3:0]           rsp_data;
  logic                 busy;

  int tests = 0;
  int fails = 0;

  logic_4b_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [2:0] op;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
    req_op[3*i +: 3] = op;
    req_x[4*i +: 4]  = x;
    req_y[4*i +: 4]  = y;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge with inputs already driven. Waits for the grant,
  // follows the transaction through EXEC and RESP, and returns at a negedge
  // shortly after RESP has been left.
  task automatic serve(input int exp_id, input logic [3:0] exp_data, input int stall, input bit drop);
    int n;
    n = 0;
    #1;
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (req_ready == '0) begin
      chk("grant_timeout", 32'd0, 32'd1);
      return;
    end
    chk("grant_onehot", $countones(req_ready), 1);
    chk("grant_id", req_ready, 1 << exp_id);
    chk("idle_busy", busy, 1'b0);
    @(negedge clk);
    if (drop) req_valid[exp_id] = 1'b0;
    #1;
    chk("exec_busy", busy, 1'b1);
    chk("exec_rsp_valid", rsp_valid, 1'b0);
    chk("exec_ready_zero", req_ready, '0);
    @(negedge clk);
    #1;
    chk("resp_valid", rsp_valid, 1'b1);
    chk("resp_id", rsp_id, exp_id);
    chk("resp_data", rsp_data, exp_data);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      #1;
      chk("stall_valid", rsp_valid, 1'b1);
      chk("stall_id", rsp_id, exp_id);
      chk("stall_data", rsp_data, exp_data);
      chk("stall_ready_zero", req_ready, '0);
      chk("stall_busy", busy, 1'b1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("resp_one_cycle", rsp_valid, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_op    = '0;
    req_x     = '0;
    req_y     = '0;

    vecs[0]  = '{0, 3'b010, 4'b0001, 4'b0001, 4'b1110};
    vecs[1]  = '{1, 3'b000, 4'b0101, 4'b0011, 4'b0001};
    vecs[2]  = '{1, 3'b001, 4'b0101, 4'b0011, 4'b0111};
    vecs[3]  = '{1, 3'b010, 4'b0101, 4'b0011, 4'b1110};
    vecs[4]  = '{1, 3'b011, 4'b0101, 4'b0011, 4'b1000};
    vecs[5]  = '{1, 3'b100, 4'b0101, 4'b0011, 4'b0110};
    vecs[6]  = '{1, 3'b101, 4'b0101, 4'b0011, 4'b1001};
    vecs[7]  = '{1, 3'b110, 4'b0101, 4'b0011, 4'b1010};
    vecs[8]  = '{1, 3'b111, 4'b0101, 4'b0011, 4'b0101};
    vecs[9]  = '{3, 3'b100, 4'b1100, 4'b1010, 4'b0110};
    vecs[10] = '{2, 3'b110, 4'b0000, 4'b1111, 4'b1111};
    vecs[11] = '{2, 3'b011, 4'b0000, 4'b0000, 4'b1111};

    #2;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, '0);
    chk("rst_rsp_data", rsp_data, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", req_ready, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-requester vectors; the other lanes carry junk operands.
    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      req_op = 12'($urandom);
      req_x  = 16'($urandom);
      req_y  = 16'($urandom);
      set_lane(vecs[v].id, vecs[v].op, vecs[v].x, vecs[v].y);
      req_valid = '0;
      req_valid[vecs[v].id] = 1'b1;
      serve(vecs[v].id, vecs[v].exp, 0, 1'b1);
    end

    // All requesters valid: strict rotation from 0, with backpressure on one.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_lane(i, 3'b111, 4'(3*i + 1), 4'hF);
    req_valid = '1;
    serve(0, 4'd1, 0, 1'b0);
    serve(1, 4'd4, 5, 1'b0);
    serve(2, 4'd7, 0, 1'b0);
    serve(3, 4'd10, 0, 1'b0);
    serve(0, 4'd1, 0, 1'b0);
    req_valid = '0;

    // After req2 is served, req3 outranks req2.
    do_reset();
    set_lane(2, 3'b000, 4'b1111, 4'b0110);
    set_lane(3, 3'b001, 4'b1000, 4'b0001);
    req_valid = 4'b0100;
    serve(2, 4'b0110, 0, 1'b1);
    req_valid = 4'b1100;
    serve(3, 4'b1001, 0, 1'b1);
    serve(2, 4'b0110, 0, 1'b1);

    // Reset during EXEC drops the transaction and restores priority to 0.
    do_reset();
    set_lane(1, 3'b111, 4'b1011, 4'b0000);
    req_valid = 4'b0010;
    #1;
    chk("pre_rst_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rsp_valid", rsp_valid, 1'b0);
    set_lane(0, 3'b101, 4'b1100, 4'b1010);
    set_lane(3, 3'b110, 4'b0011, 4'b0000);
    req_valid = 4'b1001;
    serve(0, 4'b1001, 0, 1'b1);
    serve(3, 4'b1100, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
